// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N-input W-bit registered mux with direct or round-robin channel selection
module mux_nx1_rr #(
    parameter int N    = 4,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_sel
);

    logic            load_en;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic            cand;
    logic            grant_valid;
    logic [W-1:0]    grant_data;
    logic            accept;

    assign load_en = !out_valid || out_ready;
    assign accept  = load_en && grant_valid;

    // cand: a legal channel is selected (ready may be offered even if it is not valid in mode 0)
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        cand        = 1'b0;
        grant_valid = 1'b0;
        if (!mode) begin
            grant = sel;
            cand  = int'(sel) < N;
            for (int k = 0; k < N; k++) begin
                if (k == int'(sel)) grant_valid = in_valid[k];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) idx = idx - N;
                if (!cand && in_valid[idx]) begin
                    grant       = SELW'(idx);
                    cand        = 1'b1;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < N; k++) begin
            if (k == int'(grant)) begin
                grant_data  = in_data[k*W +: W];
                in_ready[k] = rst_n && load_en && cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant;
                // the pointer only advances on round-robin accepts
                if (mode) ptr <= (int'(grant) == N - 1) ? '0 : grant + SELW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - self-checking bench for mux_nx1_rr (N=4/W=1 and N=3/W=4 instances)
module tb_mux_nx1_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       mode4, ready4, ov4;
    logic [1:0] sel4, os4;
    logic [3:0] data4, valid4, ir4;
    logic [0:0] od4;

    logic        mode3, ready3, ov3;
    logic [1:0]  sel3, os3;
    logic [11:0] data3;
    logic [2:0]  valid3, ir3;
    logic [3:0]  od3;

    mux_nx1_rr #(.N(4), .W(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4), .in_data(data4),
        .in_valid(valid4), .in_ready(ir4), .out_data(od4), .out_valid(ov4),
        .out_ready(ready4), .out_sel(os4)
    );

    mux_nx1_rr #(.N(3), .W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(data3),
        .in_valid(valid3), .in_ready(ir3), .out_data(od3), .out_valid(ov3),
        .out_ready(ready3), .out_sel(os3)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] data;
        logic [1:0] sel;
        logic       exp_out;
    } vec_t;

    vec_t vecs[7];

    // reference model state for the N=3 instance
    logic       m_valid;
    logic [3:0] m_data;
    int         m_sel, m_ptr;

    initial begin
        logic [3:0] d;
        int rr_all[8];
        int rr_sparse[4];
        int grant;
        bit cand, acc, load;
        logic [2:0] exp_ir;

        vecs[0] = '{4'b0001, 2'd0, 1'b1};
        vecs[1] = '{4'b0010, 2'd1, 1'b1};
        vecs[2] = '{4'b0100, 2'd2, 1'b1};
        vecs[3] = '{4'b1000, 2'd3, 1'b1};
        vecs[4] = '{4'b1100, 2'd0, 1'b0};
        vecs[5] = '{4'b1111, 2'd2, 1'b1};
        vecs[6] = '{4'b0010, 2'd3, 1'b0};
        rr_all    = '{0, 1, 2, 3, 0, 1, 2, 3};
        rr_sparse = '{1, 3, 1, 3};

        rst_n = 1'b0;
        mode4 = 0; sel4 = 0; data4 = 0; valid4 = 0; ready4 = 1;
        mode3 = 0; sel3 = 0; data3 = 0; valid3 = 0; ready3 = 1;

        // reset held while inputs toggle
        for (int i = 0; i < 3; i++) begin
            mode4 = 1'($urandom); sel4 = 2'($urandom); data4 = 4'($urandom); valid4 = 4'hF;
            mode3 = 1'($urandom); sel3 = 2'($urandom); valid3 = 3'h7; data3 = 12'($urandom);
            tick();
            check("rst_out_valid", ov4, 0);
            check("rst_out_data", od4, 0);
            check("rst_out_sel", os4, 0);
            check("rst_in_ready4", ir4, 0);
            check("rst_in_ready3", ir3, 0);
        end
        rst_n = 1'b1;
        mode3 = 0; valid3 = 0;

        // mode 0 sweep; the first vector also shows the first accept right after reset release
        mode4 = 0; valid4 = 4'hF; ready4 = 1;
        for (int i = 0; i < 7; i++) begin
            data4 = vecs[i].data; sel4 = vecs[i].sel;
            #1 check("sweep_in_ready", ir4, 4'b1 << vecs[i].sel);
            tick();
            check("sweep_out_valid", ov4, 1);
            check("sweep_out_data", od4, vecs[i].exp_out);
            check("sweep_out_sel", os4, vecs[i].sel);
        end

        // backpressure
        sel4 = 2; data4 = 4'b0100;
        tick();
        check("bp_first", {ov4, od4, os4}, {1'b1, 1'b1, 2'd2});
        ready4 = 0; data4 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", ir4, 0);
            tick();
            check("bp_hold", {ov4, od4, os4}, {1'b1, 1'b1, 2'd2});
        end
        ready4 = 1; sel4 = 3; data4 = 4'b1000;
        #1 check("bp_release_ready", ir4, 4'b1000);
        tick();
        check("bp_replace", {ov4, od4, os4}, {1'b1, 1'b1, 2'd3});

        // round robin, all valid: two full laps leave ptr at 0
        mode4 = 1; valid4 = 4'hF; data4 = 4'b0110; d = data4;
        for (int i = 0; i < 8; i++) begin
            #1 check("rr_all_ready", ir4, 4'b1 << rr_all[i]);
            tick();
            check("rr_all_sel", os4, rr_all[i]);
            check("rr_all_data", od4, d[rr_all[i]]);
        end

        // round robin, sparse
        valid4 = 4'b1010; data4 = 4'b1000; d = data4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_sparse", {ov4, os4, od4}, {1'b1, 2'(rr_sparse[i]), d[rr_sparse[i]]});
        end
        valid4 = 4'b0000;
        #1 check("rr_idle_ready", ir4, 0);
        tick();
        check("rr_idle_valid", ov4, 0);
        check("rr_idle_sel_hold", os4, 3);
        mode4 = 0; sel4 = 1; valid4 = 4'hF; data4 = 4'b0010;
        tick();
        check("mode0_between", {ov4, os4, od4}, {1'b1, 2'd1, 1'b1});
        mode4 = 1;
        tick();
        check("rr_resume0", os4, 0);
        tick();
        check("rr_resume1", os4, 1);
        mode4 = 0; valid4 = 0;

        // randomized run on N=3 against the reference model
        rst_n = 0;
        tick();
        rst_n = 1;
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        for (int c = 0; c < 300; c++) begin
            mode3 = 1'($urandom); sel3 = 2'($urandom_range(0, 3));
            valid3 = 3'($urandom); data3 = 12'($urandom);
            ready3 = ($urandom_range(0, 3) != 0);
            load = !m_valid || ready3;
            cand = 0; grant = 0;
            if (!mode3) begin
                grant = sel3;
                cand  = sel3 < 3;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!cand && valid3[(m_ptr + i) % 3]) begin
                        cand = 1; grant = (m_ptr + i) % 3;
                    end
                end
            end
            acc    = load && cand && valid3[grant];
            exp_ir = (load && cand) ? 3'(1 << grant) : 3'b000;
            #1 check("rand_in_ready", ir3, exp_ir);
            if (load) begin
                if (acc) begin
                    m_valid = 1; m_sel = grant; m_data = data3[grant*4 +: 4];
                    if (mode3) m_ptr = (grant + 1) % 3;
                end else begin
                    m_valid = 0;
                end
            end
            tick();
            check("rand_out", {ov3, os3, od3}, {m_valid, 2'(m_sel), m_data});
        end

        // out-of-range select on N=3
        mode3 = 0; ready3 = 1; valid3 = 3'b111; data3 = 12'h5A3; sel3 = 0;
        tick();
        check("oor_pre", {ov3, od3}, {1'b1, 4'h3});
        sel3 = 3;
        #1 check("oor_in_ready", ir3, 0);
        tick();
        check("oor_no_accept", ov3, 0);

        // asynchronous reset mid-transfer
        sel3 = 1;
        tick();
        check("async_pre", {ov3, os3, od3}, {1'b1, 2'd1, 4'hA});
        ready3 = 0;
        #1 rst_n = 0;
        #1 check("async_rst", {ov3, os3, od3, ir3}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the 4x1 behavioural mux in two ways: the width and channel count are configurable, and a round-robin mode scans the valid channels automatically. It sits between multiple producer channels and a single consumer, with one output register stage.

## Interface
- N, 4, number of input channels (N >= 2)
- W, 1, data width per channel in bits
- SELW, $clog2(N), select/pointer width (derived; do not override)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SELW  channel select, used in mode 0
- in_data  input  N*W  channel k occupies bits [k*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  W  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready
- out_sel  output  SELW  channel index of the beat held in out_data

## Operation
- Clock is clk. Reset is asynchronous and active-low on rst_n; assertion takes effect immediately, without waiting for a clock edge.
- Load enable: load_en = !out_valid || out_ready. This lets the output register refill in the same cycle it drains.
- Mode 0 (direct): the candidate channel is sel.
  - If sel < N and in_valid[sel] is high and load_en is high, the beat is accepted.
  - in_ready[k] = load_en && (k == sel) && (sel < N).
  - If sel >= N (possible only when N is not a power of 2), every in_ready is 0 and nothing is accepted.
- Mode 1 (round-robin): a pointer ptr (SELW bits) sets the search start.
  - The grant goes to the first k with in_valid[k] = 1, searching ptr, ptr+1, ... and wrapping at N-1 back to 0.
  - in_ready[grant] = load_en; all other in_ready bits are 0.
  - On an accepted beat, ptr <= (grant == N-1) ? 0 : grant+1.
  - If no channel is valid, nothing is accepted and ptr holds.
- ptr changes only on round-robin accepts. It holds while in mode 0.
- mode and sel are sampled combinationally each cycle. A change takes effect on the next accept; no beat in flight is lost or duplicated.
- On accept, the registers update: out_data <= in_data[grant*W +: W], out_sel <= grant, out_valid <= 1.
- If load_en is high and nothing is accepted, out_valid <= 0. out_data and out_sel hold their values.
- If out_valid is high and out_ready is low, out_data, out_sel and out_valid hold, and all in_ready bits are 0 (backpressure).

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0. While in reset, in_ready = all 0.
- Latency: a beat accepted at edge t appears on out_* immediately after edge t (1 cycle).
- Throughput: 1 beat per cycle when out_ready is held high and a candidate is valid.
- in_ready depends combinationally on out_valid, out_ready, mode, sel, in_valid and ptr. It does not depend on in_data.
- Simultaneous output drain and new accept in the same cycle: the new beat replaces the old one, with no bubble.
- Reset asserted mid-transfer: the held beat is discarded and all outputs return to their reset values. Producers must re-present their data after reset.
- Wrap-around: ptr = N-1 followed by a grant at N-1 sets ptr to 0.

## Test plan
- Reset: hold rst_n = 0 while toggling the inputs -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0000. Release rst_n -> the first accept occurs on the next edge.
- Mode 0 sweep (N=4, W=1, out_ready=1, in_valid=1111):
  - Apply in_data/sel = 0001/00, 0010/01, 0100/10, 1000/11, 1100/00, 1111/10, 0010/11.
  - Required out_data one cycle later: 1, 1, 1, 1, 0, 1, 0.
  - out_sel must match sel, and in_ready must be one-hot on sel.
- Backpressure (mode 0, sel=2, in_data=0100): set out_ready = 0 for 3 cycles after the first beat.
  - out_valid, out_data and out_sel hold, and in_ready = 0000.
  - Raise out_ready -> a new beat is accepted on the same edge the old one drains.
- Round-robin, all valid (mode 1, in_valid=1111, out_ready=1) -> out_sel sequence 0,1,2,3,0,1, with ptr wrapping from 3 to 0.
- Round-robin, sparse (in_valid=1010, ptr=0):
  - out_sel sequence 1,3,1,3.
  - Drop in_valid to 0000 -> out_valid falls to 0 the next cycle and ptr holds.
  - Switch to mode 0 with sel=1, then back to mode 1 -> arbitration resumes from the held ptr.
- Out-of-range select (N=3, mode 0, sel=3, all valid) -> in_ready = 000 and no beat is accepted.
  - Then assert rst_n low mid-transfer with out_valid=1 -> out_valid = 0 immediately, without waiting for a clock edge.
